// File: rtl/sdram_arb_pkg.sv
// Shared types, client count and default parameters for the two-client
// SDRAM host-port arbiter.
package sdram_arb_pkg;

    localparam int NUM_CLIENTS       = 2;
    localparam int DEFAULT_DW        = 16;
    localparam int DEFAULT_BURST_LEN = 128;
    localparam int DEFAULT_RD_LAT    = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // Round-robin pick: on a tie the client that was not granted last wins.
    function automatic logic rr_pick(input logic [NUM_CLIENTS-1:0] req,
                                     input logic                   last_gnt);
        if (req[0] && req[1]) begin
            return ~last_gnt;
        end
        return req[1];
    endfunction

endpackage

// File: rtl/sdram_arb_rdpipe.sv
// Read-return delay line: carries a valid bit and a 1-bit client tag so each
// returning word is routed to the client that issued the read.
module sdram_arb_rdpipe #(
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    input  logic in_id,
    output logic out_valid,
    output logic out_id,
    output logic any_valid
);

    logic [RD_LAT-1:0] vld_q;
    logic [RD_LAT-1:0] id_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q <= '0;
            id_q  <= '0;
        end else begin
            vld_q[0] <= in_valid;
            id_q[0]  <= in_id;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                id_q[i]  <= id_q[i-1];
            end
        end
    end

    assign out_valid = vld_q[RD_LAT-1];
    assign out_id    = id_q[RD_LAT-1];
    assign any_valid = |vld_q;

endmodule

// File: rtl/sdram_port_arbiter.sv
// Two-client burst arbiter in front of the SDRAM controller host FIFOs:
// round-robin grant, atomic fixed-length bursts, tagged read returns.
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int DW        = DEFAULT_DW,
    parameter int BURST_LEN = DEFAULT_BURST_LEN,
    parameter int RD_LAT    = DEFAULT_RD_LAT
) (
    input  logic                   iCLK,
    input  logic                   iRST_n,
    input  logic [NUM_CLIENTS-1:0] iREQ,
    input  logic [NUM_CLIENTS-1:0] iRW,
    input  logic [DW-1:0]          iWDATA0,
    input  logic [DW-1:0]          iWDATA1,
    output logic [NUM_CLIENTS-1:0] oGNT,
    output logic [NUM_CLIENTS-1:0] oWACK,
    output logic [DW-1:0]          oRDATA,
    output logic [NUM_CLIENTS-1:0] oRVALID,
    input  logic                   iFIFO_RDY,
    output logic                   write,
    output logic [DW-1:0]          writedata,
    output logic                   read,
    input  logic [DW-1:0]          readdata,
    output logic                   oBUSY,
    output logic [1:0]             dbg_state
);

    localparam int             CW        = $clog2(BURST_LEN + 1);
    localparam logic [CW-1:0]  LAST_WORD = CW'(BURST_LEN - 1);

    // Handshake: a word moves on a cycle where write or read is high; those
    // strobes are only raised while iFIFO_RDY is high, so strobe == transfer
    // and oWACK/the word counter follow the strobe in the same cycle.

    state_t          state_q;
    state_t          state_d;
    logic            gnt_idx_q;
    logic            rw_q;
    logic            last_gnt_q;
    logic [CW-1:0]   word_cnt_q;
    logic [DW-1:0]   rdata_q;
    logic            winner;
    logic            xfer;
    logic            pipe_valid;
    logic            pipe_id;
    logic            pipe_any;

    assign winner = rr_pick(iREQ, last_gnt_q);

    // A word is never issued in a cycle whose edge samples reset, so an
    // aborted burst cannot leave a read outstanding in the FIFO.
    assign xfer = (state_q == ST_BURST) && iFIFO_RDY && iRST_n;

    always_ff @(posedge iCLK) begin
        if (!iRST_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (|iREQ) begin
                    state_d = ST_BURST;
                end
            end
            ST_BURST: begin
                if (xfer && (word_cnt_q == LAST_WORD)) begin
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (!iRST_n) begin
            gnt_idx_q  <= 1'b0;
            rw_q       <= 1'b0;
            last_gnt_q <= 1'b1;
            word_cnt_q <= '0;
            rdata_q    <= '0;
        end else begin
            if ((state_q == ST_IDLE) && (|iREQ)) begin
                gnt_idx_q  <= winner;
                rw_q       <= iRW[winner];
                word_cnt_q <= '0;
            end else if (xfer) begin
                word_cnt_q <= word_cnt_q + 1'b1;
            end
            if (state_q == ST_GAP) begin
                last_gnt_q <= gnt_idx_q;
            end
            if (pipe_valid) begin
                rdata_q <= readdata;
            end
        end
    end

    sdram_arb_rdpipe #(
        .RD_LAT (RD_LAT)
    ) u_rdpipe (
        .clk       (iCLK),
        .rst_n     (iRST_n),
        .in_valid  (read),
        .in_id     (gnt_idx_q),
        .out_valid (pipe_valid),
        .out_id    (pipe_id),
        .any_valid (pipe_any)
    );

    always_comb begin
        oGNT      = '0;
        oWACK     = '0;
        write     = 1'b0;
        read      = 1'b0;
        writedata = '0;
        if (state_q == ST_BURST) begin
            oGNT = gnt_idx_q ? 2'b10 : 2'b01;
        end
        if (xfer && rw_q) begin
            write     = 1'b1;
            writedata = gnt_idx_q ? iWDATA1 : iWDATA0;
            oWACK     = oGNT;
        end
        if (xfer && !rw_q) begin
            read = 1'b1;
        end
    end

    // Returned data is shown live on its valid cycle and held afterwards.
    assign oRVALID   = pipe_valid ? (pipe_id ? 2'b10 : 2'b01) : 2'b00;
    assign oRDATA    = pipe_valid ? readdata : rdata_q;
    assign oBUSY     = (state_q != ST_IDLE) || pipe_any;
    assign dbg_state = state_q;

    a_no_rw_overlap: assert property (@(posedge iCLK) disable iff (!iRST_n)
        !(write && read));
    a_gnt_onehot: assert property (@(posedge iCLK) disable iff (!iRST_n)
        $onehot0(oGNT));

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: scenario tasks plus a transaction-level
// reference model of bursts, arbitration and read returns.
module tb_sdram_port_arbiter;

    localparam int DW = 16;
    localparam int BL = 4;
    localparam int RL = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    req;
    logic [1:0]    rw;
    logic [DW-1:0] wdata0;
    logic [DW-1:0] wdata1;
    logic [1:0]    gnt;
    logic [1:0]    wack;
    logic [DW-1:0] rdata;
    logic [1:0]    rvalid;
    logic          fifo_rdy;
    logic          write;
    logic [DW-1:0] writedata;
    logic          read;
    logic [DW-1:0] readdata;
    logic          busy;
    logic [1:0]    dbg_state;

    sdram_port_arbiter #(
        .DW        (DW),
        .BURST_LEN (BL),
        .RD_LAT    (RL)
    ) dut (
        .iCLK      (clk),
        .iRST_n    (rst_n),
        .iREQ      (req),
        .iRW       (rw),
        .iWDATA0   (wdata0),
        .iWDATA1   (wdata1),
        .oGNT      (gnt),
        .oWACK     (wack),
        .oRDATA    (rdata),
        .oRVALID   (rvalid),
        .iFIFO_RDY (fifo_rdy),
        .write     (write),
        .writedata (writedata),
        .read      (read),
        .readdata  (readdata),
        .oBUSY     (busy),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model: who owns the port, words moved, cool-down after a
    // burst, and the list of read returns still owed (due cycle + client).
    int            m_owner = -1;
    int            m_words = 0;
    bit            m_rw    = 1'b0;
    int            m_last  = 1;
    int            m_gap   = 0;
    int            ret_due[$];
    int            ret_cli[$];
    logic [DW-1:0] m_hold  = '0;

    // Memory model behind the FIFO: answers each read RL cycles later.
    int            mem_due[$];
    logic [DW-1:0] mem_val = 16'h0100;

    // Scenario observations.
    int            obs_write, obs_read, obs_stall_strobe;
    int            obs_wack[2];
    int            obs_rvalid[2];
    logic [1:0]    gnt_hist[$];
    logic [DW-1:0] rv1_data[$];
    logic [1:0]    prev_gnt = 2'b00;

    task automatic clear_obs();
        obs_write = 0; obs_read = 0; obs_stall_strobe = 0;
        obs_wack[0] = 0; obs_wack[1] = 0;
        obs_rvalid[0] = 0; obs_rvalid[1] = 0;
        gnt_hist.delete();
        rv1_data.delete();
    endtask

    // One clock: supply readdata, score all outputs, advance the model.
    task automatic cycle();
        logic [1:0]    e_gnt, e_wack, e_rvalid;
        logic          e_write, e_read, e_busy, xfer;
        logic [DW-1:0] e_wdata, e_rdata;
        int            w;
        if (mem_due.size() > 0 && mem_due[0] == cyc) begin
            readdata = mem_val;
            mem_val  = mem_val + 16'd1;
            void'(mem_due.pop_front());
        end else begin
            readdata = DW'($urandom);
        end
        @(negedge clk);
        xfer     = (m_owner >= 0) && fifo_rdy && rst_n;
        e_gnt    = (m_owner >= 0) ? 2'(1 << m_owner) : 2'b00;
        e_write  = xfer && m_rw;
        e_read   = xfer && !m_rw;
        e_wdata  = e_write ? ((m_owner == 1) ? wdata1 : wdata0) : '0;
        e_wack   = e_write ? e_gnt : 2'b00;
        e_busy   = (m_owner >= 0) || (m_gap > 0) || (ret_due.size() > 0);
        e_rvalid = 2'b00;
        e_rdata  = m_hold;
        if (ret_due.size() > 0 && ret_due[0] == cyc) begin
            e_rvalid = 2'(1 << ret_cli[0]);
            e_rdata  = readdata;
            m_hold   = readdata;
            void'(ret_due.pop_front());
            void'(ret_cli.pop_front());
        end
        n_tests += 8;
        if (gnt !== e_gnt) begin n_fail++; $display("FAIL gnt cyc=%0d got=%b exp=%b", cyc, gnt, e_gnt); end
        if (write !== e_write) begin n_fail++; $display("FAIL write cyc=%0d got=%b exp=%b", cyc, write, e_write); end
        if (read !== e_read) begin n_fail++; $display("FAIL read cyc=%0d got=%b exp=%b", cyc, read, e_read); end
        if (writedata !== e_wdata) begin n_fail++; $display("FAIL writedata cyc=%0d got=%h exp=%h", cyc, writedata, e_wdata); end
        if (wack !== e_wack) begin n_fail++; $display("FAIL wack cyc=%0d got=%b exp=%b", cyc, wack, e_wack); end
        if (rvalid !== e_rvalid) begin n_fail++; $display("FAIL rvalid cyc=%0d got=%b exp=%b", cyc, rvalid, e_rvalid); end
        if (rdata !== e_rdata) begin n_fail++; $display("FAIL rdata cyc=%0d got=%h exp=%h", cyc, rdata, e_rdata); end
        if (busy !== e_busy) begin n_fail++; $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, e_busy); end
        if (write === 1'b1) obs_write++;
        if (read === 1'b1) obs_read++;
        if (wack[0] === 1'b1) obs_wack[0]++;
        if (wack[1] === 1'b1) obs_wack[1]++;
        if (rvalid[0] === 1'b1) obs_rvalid[0]++;
        if (rvalid[1] === 1'b1) begin obs_rvalid[1]++; rv1_data.push_back(rdata); end
        if (!fifo_rdy && (write || read || wack != 2'b00)) obs_stall_strobe++;
        if (gnt != 2'b00 && prev_gnt == 2'b00) gnt_hist.push_back(gnt);
        prev_gnt = gnt;
        if (read === 1'b1) mem_due.push_back(cyc + RL);
        if (!rst_n) begin
            m_owner = -1; m_gap = 0; m_last = 1; m_hold = '0;
            ret_due.delete(); ret_cli.delete(); mem_due.delete();
        end else begin
            if (e_read) begin
                ret_due.push_back(cyc + RL);
                ret_cli.push_back(m_owner);
            end
            if (m_owner >= 0) begin
                if (xfer) m_words++;
                if (m_words == BL) begin
                    m_last  = m_owner;
                    m_owner = -1;
                    m_gap   = 1;
                end
            end else if (m_gap > 0) begin
                m_gap--;
            end else if (req != 2'b00) begin
                w       = (req == 2'b11) ? (1 - m_last) : (req[1] ? 1 : 0);
                m_owner = w;
                m_words = 0;
                m_rw    = rw[w];
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            wdata0 = DW'($urandom);
            wdata1 = DW'($urandom);
            cycle();
        end
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = 2'b00; rw = 2'b00; fifo_rdy = 1'b1;
        wdata0 = '0; wdata1 = '0; readdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests += 5;
        if (gnt !== 2'b00 || wack !== 2'b00) begin n_fail++; $display("FAIL reset_gnt_wack got=%b/%b exp=00/00", gnt, wack); end
        if (rvalid !== 2'b00) begin n_fail++; $display("FAIL reset_rvalid got=%b exp=00", rvalid); end
        if (write !== 1'b0 || read !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_strobes got=%b%b%b exp=000", write, read, busy); end
        if (writedata !== '0 || rdata !== '0) begin n_fail++; $display("FAIL reset_data got=%h/%h exp=0/0", writedata, rdata); end
        if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_write_burst();
        clear_obs();
        req = 2'b01; rw = 2'b01; fifo_rdy = 1'b1;
        run(1);
        req = 2'b00;
        run(7);
        n_tests += 4;
        if (obs_wack[0] != BL || obs_write != BL) begin n_fail++; $display("FAIL wr_burst_words got=%0d/%0d exp=%0d", obs_wack[0], obs_write, BL); end
        if (gnt_hist.size() != 1) begin n_fail++; $display("FAIL wr_burst_grants got=%0d exp=1", gnt_hist.size()); end
        else if (gnt_hist[0] !== 2'b01) begin n_fail++; $display("FAIL wr_burst_gnt got=%b exp=01", gnt_hist[0]); end
        if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL wr_burst_idle got=%0d exp=0", dbg_state); end
        if (obs_wack[1] != 0) begin n_fail++; $display("FAIL wr_burst_wack1 got=%0d exp=0", obs_wack[1]); end
    endtask

    task automatic test_round_robin();
        logic [1:0] want;
        pulse_reset();
        clear_obs();
        req = 2'b11; rw = 2'($urandom); fifo_rdy = 1'b1;
        run(18);
        req = 2'b00;
        run(8);
        n_tests++;
        if (gnt_hist.size() < 3) begin n_fail++; $display("FAIL rr_count got=%0d exp>=3", gnt_hist.size()); end
        for (int i = 0; i < 3 && i < gnt_hist.size(); i++) begin
            want = (i % 2 == 0) ? 2'b01 : 2'b10;
            n_tests++;
            if (gnt_hist[i] !== want) begin n_fail++; $display("FAIL rr_order[%0d] got=%b exp=%b", i, gnt_hist[i], want); end
        end
    endtask

    task automatic test_read_latency();
        clear_obs();
        mem_val = 16'h0100;
        req = 2'b10; rw = 2'b00; fifo_rdy = 1'b1;
        run(1);
        req = 2'b00; rw = 2'b11;
        run(9);
        n_tests++;
        if (obs_rvalid[1] != BL || obs_rvalid[0] != 0) begin n_fail++; $display("FAIL rd_count got=%0d/%0d exp=%0d/0", obs_rvalid[1], obs_rvalid[0], BL); end
        for (int i = 0; i < rv1_data.size(); i++) begin
            n_tests++;
            if (rv1_data[i] !== 16'h0100 + 16'(i)) begin n_fail++; $display("FAIL rd_ramp[%0d] got=%h exp=%h", i, rv1_data[i], 16'h0100 + 16'(i)); end
        end
    endtask

    task automatic test_stall();
        clear_obs();
        req = 2'b01; rw = 2'b01; fifo_rdy = 1'b1;
        run(1);
        req = 2'b00;
        for (int i = 0; i < 12; i++) begin
            fifo_rdy = (i % 2 == 0);
            run(1);
        end
        fifo_rdy = 1'b1;
        run(2);
        n_tests += 2;
        if (obs_write != BL) begin n_fail++; $display("FAIL stall_words got=%0d exp=%0d", obs_write, BL); end
        if (obs_stall_strobe != 0) begin n_fail++; $display("FAIL stall_strobe got=%0d exp=0", obs_stall_strobe); end
    endtask

    task automatic test_reset_mid_burst();
        clear_obs();
        req = 2'b01; rw = 2'b00; fifo_rdy = 1'b1;
        run(1);
        req = 2'b00;
        run(2);
        pulse_reset();
        clear_obs();
        run(6);
        n_tests += 2;
        if (obs_rvalid[0] != 0 || obs_rvalid[1] != 0) begin n_fail++; $display("FAIL rst_late_rvalid got=%0d/%0d exp=0/0", obs_rvalid[0], obs_rvalid[1]); end
        if (obs_read != 0 || gnt_hist.size() != 0) begin n_fail++; $display("FAIL rst_abort got=%0d/%0d exp=0/0", obs_read, gnt_hist.size()); end
        req = 2'b11; rw = 2'b11;
        run(2);
        req = 2'b00;
        run(6);
        n_tests++;
        if (gnt_hist.size() == 0 || gnt_hist[0] !== 2'b01) begin n_fail++; $display("FAIL rst_tie got=%b exp=01", (gnt_hist.size() > 0) ? gnt_hist[0] : 2'b00); end
    endtask

    task automatic test_atomic();
        clear_obs();
        req = 2'b01; rw = 2'b01; fifo_rdy = 1'b1;
        run(2);
        req = 2'b00; rw = 2'b00;
        run(7);
        n_tests++;
        if (obs_write != BL || obs_read != 0) begin n_fail++; $display("FAIL atomic_words got=%0d/%0d exp=%0d/0", obs_write, obs_read, BL); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            req      = 2'($urandom_range(0, 3));
            rw       = 2'($urandom_range(0, 3));
            fifo_rdy = ($urandom_range(0, 3) != 0);
            run(1);
        end
        req = 2'b00; fifo_rdy = 1'b1;
        run(12);
    endtask

    initial begin
        clear_obs();
        test_reset();
        test_write_burst();
        test_round_robin();
        test_read_latency();
        test_stall();
        test_reset_mid_burst();
        test_atomic();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

endmodule
